// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl: boot-time ID/timestamp check of the sysid slave, then host pass-through access.
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS = 32'h691A_E385,
  parameter int unsigned START_DELAY = 16,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        recheck,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        host_address,
  input  logic        host_read,
  output logic [31:0] host_readdata,
  output logic        host_waitrequest,
  output logic        check_busy,
  output logic        check_done,
  output logic        check_pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout_err
);

  localparam int unsigned DLY_W  = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;
  localparam int unsigned WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Last delay count before the first read; START_DELAY=0 makes this 0 so DELAY lasts one cycle.
  localparam logic [DLY_W-1:0]  DLY_LAST = DLY_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_DELAY = 2'd0,
    S_RD_ID = 2'd1,
    S_RD_TS = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               id_q, id_d;
  logic               ts_q, ts_d;
  logic               to_q, to_d;
  logic               pass_q, pass_d;
  logic               pend_q, pend_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state, sticky flag and counter logic for the check sequence.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    wait_d  = wait_q;
    id_d    = id_q;
    ts_d    = ts_q;
    to_d    = to_q;
    pass_d  = pass_q;
    pend_d  = pend_q | recheck;

    case (state_q)
      S_DELAY: begin
        if (dly_q == DLY_LAST) begin
          state_d = S_RD_ID;
        end else if (dly_q != '1) begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      S_RD_ID, S_RD_TS: begin
        // An accept always beats a timeout in the same cycle.
        if (!avm_waitrequest) begin
          wait_d = '0;
          if (state_q == S_RD_ID) begin
            id_d    = id_q | (avm_readdata != EXPECTED_ID);
            state_d = S_RD_TS;
          end else begin
            ts_d    = ts_q | (avm_readdata != EXPECTED_TS);
            state_d = S_DONE;
          end
        end else if (wait_q == WAIT_MAX) begin
          to_d    = 1'b1;
          wait_d  = '0;
          state_d = S_DONE;
        end else if (wait_q != '1) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DONE: begin
        // Never cut a host read that the slave is still stalling.
        if (pend_q && !(host_read && avm_waitrequest)) begin
          state_d = S_RD_ID;
          pend_d  = recheck;
          wait_d  = '0;
          id_d    = 1'b0;
          ts_d    = 1'b0;
          to_d    = 1'b0;
          pass_d  = 1'b0;
        end
      end
      default: state_d = S_DELAY;
    endcase

    if ((state_q != S_DONE) && (state_d == S_DONE)) begin
      pass_d = !(id_d | ts_d | to_d);
    end

    busy_d = (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // Bus ownership: checker drives the master until DONE, then the host path is a straight wire.
  always_comb begin
    avm_read         = 1'b0;
    avm_address      = 1'b0;
    host_waitrequest = 1'b1;
    host_readdata    = '0;
    case (state_q)
      S_RD_ID: begin
        avm_read = 1'b1;
      end
      S_RD_TS: begin
        avm_read    = 1'b1;
        avm_address = 1'b1;
      end
      S_DONE: begin
        avm_read         = host_read;
        avm_address      = host_address;
        host_waitrequest = avm_waitrequest;
        host_readdata    = avm_readdata;
      end
      default: ;
    endcase
  end

  // State, counters and status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_DELAY;
      dly_q   <= '0;
      wait_q  <= '0;
      id_q    <= 1'b0;
      ts_q    <= 1'b0;
      to_q    <= 1'b0;
      pass_q  <= 1'b0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      wait_q  <= wait_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      to_q    <= to_d;
      pass_q  <= pass_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign check_busy  = busy_q;
  assign check_done  = done_q;
  assign check_pass  = pass_q;
  assign id_mismatch = id_q;
  assign ts_mismatch = ts_q;
  assign timeout_err = to_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// tb_sysid_check_ctrl: randomized and directed checks of sysid_check_ctrl against a cycle-count model.
module tb_sysid_check_ctrl;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h691A_E385;
  localparam int DLY = 16;
  localparam int TMO = 255;

  logic        clock = 1'b0;
  logic        reset;
  logic        recheck;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        host_address;
  logic        host_read;
  logic [31:0] host_readdata;
  logic        host_waitrequest;
  logic        check_busy;
  logic        check_done;
  logic        check_pass;
  logic        id_mismatch;
  logic        ts_mismatch;
  logic        timeout_err;

  logic [31:0] mem [2];
  int          stall_cfg [2];
  int          stall_n;
  int          acc_cnt [2];
  int          vectors = 0;
  int          miscompares = 0;

  sysid_check_ctrl #(
    .EXPECTED_ID (EXP_ID),
    .EXPECTED_TS (EXP_TS),
    .START_DELAY (DLY),
    .TIMEOUT     (TMO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .recheck          (recheck),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_readdata     (avm_readdata),
    .avm_waitrequest  (avm_waitrequest),
    .host_address     (host_address),
    .host_read        (host_read),
    .host_readdata    (host_readdata),
    .host_waitrequest (host_waitrequest),
    .check_busy       (check_busy),
    .check_done       (check_done),
    .check_pass       (check_pass),
    .id_mismatch      (id_mismatch),
    .ts_mismatch      (ts_mismatch),
    .timeout_err      (timeout_err)
  );

  always #5 clock = ~clock;

  // Sysid slave model: zero-latency data, stalls each read stall_cfg[addr] cycles.
  assign avm_readdata    = mem[avm_address];
  assign avm_waitrequest = avm_read && (stall_n < stall_cfg[avm_address]);

  always @(posedge clock or posedge reset) begin
    if (reset) stall_n <= 0;
    else if (avm_read && avm_waitrequest) stall_n <= stall_n + 1;
    else stall_n <= 0;
  end

  always @(posedge clock) begin
    if (avm_read && !avm_waitrequest) acc_cnt[avm_address] <= acc_cnt[avm_address] + 1;
  end

  // Cycles one read occupies: stalls plus the accept, or the abort after TMO tolerated stalls.
  function automatic int rd_cycles(input int s);
    return ((s > TMO) ? TMO : s) + 1;
  endfunction

  task automatic apply_reset;
    @(negedge clock);
    reset = 1'b1; recheck = 1'b0; host_read = 1'b0; host_address = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    bit seen;
    seen = 1'b0;
    cycles = -1;
    for (int k = 1; k <= budget && !seen; k++) begin
      @(negedge clock);
      if (check_done) begin seen = 1'b1; cycles = k; end
    end
  endtask

  task automatic test_reset;
    @(negedge clock);
    reset = 1'b1;
    #1;
    vectors++;
    if ({check_busy, check_done, check_pass, id_mismatch, ts_mismatch, timeout_err, avm_read, host_waitrequest} !== 8'b1000_0001) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected %b",
               {check_busy, check_done, check_pass, id_mismatch, ts_mismatch, timeout_err, avm_read, host_waitrequest}, 8'b1000_0001);
    end
    vectors++;
    if (host_readdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_host_readdata: got %h expected %h", host_readdata, 32'h0);
    end
  endtask

  task automatic test_nominal;
    int rise, done_at;
    rise = -1; done_at = -1;
    mem[0] = EXP_ID; mem[1] = EXP_TS;
    apply_reset;
    for (int k = 1; k <= 80 && done_at < 0; k++) begin
      @(negedge clock);
      if (rise < 0 && avm_read) rise = k;
      if (check_done) done_at = k;
    end
    vectors++;
    if (rise !== DLY) begin
      miscompares++; $display("FAIL nominal_read_rise: got %0d expected %0d", rise, DLY);
    end
    vectors++;
    if (done_at !== DLY + rd_cycles(0) + rd_cycles(0)) begin
      miscompares++; $display("FAIL nominal_done_cycle: got %0d expected %0d", done_at, DLY + 2);
    end
    vectors++;
    if ({check_busy, check_pass, id_mismatch, ts_mismatch, timeout_err} !== 5'b01000) begin
      miscompares++;
      $display("FAIL nominal_status: got %b expected %b",
               {check_busy, check_pass, id_mismatch, ts_mismatch, timeout_err}, 5'b01000);
    end
  endtask

  task automatic test_id_mismatch;
    int c, a1;
    mem[0] = 32'h0000_0001; mem[1] = EXP_TS;
    apply_reset;
    a1 = acc_cnt[1];
    wait_done(100, c);
    vectors++;
    if (c !== DLY + 2) begin
      miscompares++; $display("FAIL idmis_done_cycle: got %0d expected %0d", c, DLY + 2);
    end
    vectors++;
    if ({check_pass, id_mismatch, ts_mismatch, timeout_err} !== 4'b0100) begin
      miscompares++;
      $display("FAIL idmis_flags: got %b expected %b", {check_pass, id_mismatch, ts_mismatch, timeout_err}, 4'b0100);
    end
    vectors++;
    if (acc_cnt[1] - a1 !== 1) begin
      miscompares++; $display("FAIL idmis_ts_read_done: got %0d expected %0d", acc_cnt[1] - a1, 1);
    end
    mem[0] = EXP_ID;
  endtask

  task automatic test_timeout;
    int c;
    stall_cfg[1] = 100000;
    apply_reset;
    wait_done(400, c);
    vectors++;
    if (c !== DLY + rd_cycles(0) + rd_cycles(100000)) begin
      miscompares++; $display("FAIL timeout_done_cycle: got %0d expected %0d", c, DLY + 1 + TMO + 1);
    end
    vectors++;
    if ({check_pass, id_mismatch, ts_mismatch, timeout_err, avm_read} !== 5'b00010) begin
      miscompares++;
      $display("FAIL timeout_flags: got %b expected %b",
               {check_pass, id_mismatch, ts_mismatch, timeout_err, avm_read}, 5'b00010);
    end
    stall_cfg[1] = 0;
  endtask

  task automatic test_accept_wins;
    int c;
    stall_cfg[0] = TMO;
    apply_reset;
    wait_done(400, c);
    vectors++;
    if (c !== DLY + (TMO + 1) + 1) begin
      miscompares++; $display("FAIL accept_wins_cycle: got %0d expected %0d", c, DLY + TMO + 2);
    end
    vectors++;
    if ({check_pass, id_mismatch, ts_mismatch, timeout_err} !== 4'b1000) begin
      miscompares++;
      $display("FAIL accept_wins_flags: got %b expected %b", {check_pass, id_mismatch, ts_mismatch, timeout_err}, 4'b1000);
    end
    stall_cfg[0] = 0;
  endtask

  task automatic test_host_blocked;
    bit seen;
    seen = 1'b0;
    apply_reset;
    host_read = 1'b1; host_address = 1'b1;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clock);
      vectors++;
      if (!check_done) begin
        if ({host_waitrequest, host_readdata} !== {1'b1, 32'h0}) begin
          miscompares++;
          $display("FAIL host_blocked_cycle%0d: got %b/%h expected 1/00000000", k, host_waitrequest, host_readdata);
        end
      end else begin
        seen = 1'b1;
        if ({host_waitrequest, host_readdata} !== {1'b0, EXP_TS}) begin
          miscompares++;
          $display("FAIL host_passthru: got %b/%h expected 0/%h", host_waitrequest, host_readdata, EXP_TS);
        end
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL host_blocked_done: got 0 expected 1");
    end
    host_read = 1'b0;
  endtask

  task automatic test_recheck_host_stall;
    int c;
    mem[1] = 32'hDEAD_BEEF;
    apply_reset;
    wait_done(100, c);
    vectors++;
    if ({check_pass, id_mismatch, ts_mismatch, timeout_err} !== 4'b0010) begin
      miscompares++;
      $display("FAIL rchk_pre_flags: got %b expected %b", {check_pass, id_mismatch, ts_mismatch, timeout_err}, 4'b0010);
    end
    mem[1] = EXP_TS; stall_cfg[0] = 3;
    @(negedge clock);
    host_read = 1'b1; host_address = 1'b0; recheck = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      recheck = 1'b0;
      vectors++;
      if ({check_done, host_waitrequest} !== {1'b1, (k < 3)}) begin
        miscompares++;
        $display("FAIL rchk_hold_cycle%0d: got %b expected %b", k, {check_done, host_waitrequest}, {1'b1, (k < 3)});
      end
    end
    vectors++;
    if (host_readdata !== mem[0]) begin
      miscompares++; $display("FAIL rchk_host_data: got %h expected %h", host_readdata, mem[0]);
    end
    @(negedge clock);
    host_read = 1'b0;
    vectors++;
    if ({check_busy, check_done, check_pass, id_mismatch, ts_mismatch, timeout_err} !== 6'b100000) begin
      miscompares++;
      $display("FAIL rchk_restart: got %b expected %b",
               {check_busy, check_done, check_pass, id_mismatch, ts_mismatch, timeout_err}, 6'b100000);
    end
    wait_done(100, c);
    vectors++;
    if (c !== rd_cycles(3) + rd_cycles(0)) begin
      miscompares++; $display("FAIL rchk_rerun_cycles: got %0d expected %0d", c, 5);
    end
    vectors++;
    if ({check_pass, id_mismatch, ts_mismatch, timeout_err} !== 4'b1000) begin
      miscompares++;
      $display("FAIL rchk_rerun_flags: got %b expected %b", {check_pass, id_mismatch, ts_mismatch, timeout_err}, 4'b1000);
    end
    stall_cfg[0] = 0;
  endtask

  task automatic test_recheck_on_done_entry;
    int c;
    bit stay;
    apply_reset;
    for (int k = 1; k <= DLY + 1; k++) @(negedge clock);
    recheck = 1'b1;
    @(negedge clock);
    recheck = 1'b0;
    vectors++;
    if (check_done !== 1'b1) begin
      miscompares++; $display("FAIL entry_done_pulse: got %b expected 1", check_done);
    end
    @(negedge clock);
    vectors++;
    if ({check_busy, check_done} !== 2'b10) begin
      miscompares++; $display("FAIL entry_restart: got %b expected 10", {check_busy, check_done});
    end
    wait_done(100, c);
    vectors++;
    if (c !== 2) begin
      miscompares++; $display("FAIL entry_rerun_cycles: got %0d expected 2", c);
    end
    stay = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (!check_done) stay = 1'b0;
    end
    vectors++;
    if (stay !== 1'b1) begin
      miscompares++; $display("FAIL entry_single_rerun: got %b expected 1", stay);
    end
  endtask

  task automatic test_recheck_while_busy;
    int c;
    apply_reset;
    for (int k = 1; k <= 4; k++) @(negedge clock);
    recheck = 1'b1;
    @(negedge clock);
    recheck = 1'b0;
    wait_done(100, c);
    vectors++;
    if (c !== DLY + 2 - 5) begin
      miscompares++; $display("FAIL busy_rchk_first: got %0d expected %0d", c, DLY - 3);
    end
    @(negedge clock);
    vectors++;
    if (check_busy !== 1'b1) begin
      miscompares++; $display("FAIL busy_rchk_restart: got %b expected 1", check_busy);
    end
    wait_done(100, c);
    vectors++;
    if (c !== 2) begin
      miscompares++; $display("FAIL busy_rchk_second: got %0d expected 2", c);
    end
  endtask

  task automatic test_async_reset;
    int c;
    stall_cfg[1] = 50;
    apply_reset;
    for (int k = 1; k <= DLY + 6; k++) @(negedge clock);
    vectors++;
    if ({avm_read, avm_address, check_busy} !== 3'b111) begin
      miscompares++; $display("FAIL areset_in_rd_ts: got %b expected 111", {avm_read, avm_address, check_busy});
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({check_busy, check_done, check_pass, id_mismatch, ts_mismatch, timeout_err, avm_read, host_waitrequest} !== 8'b1000_0001) begin
      miscompares++;
      $display("FAIL areset_outputs: got %b expected %b",
               {check_busy, check_done, check_pass, id_mismatch, ts_mismatch, timeout_err, avm_read, host_waitrequest}, 8'b1000_0001);
    end
    @(negedge clock);
    reset = 1'b0; stall_cfg[1] = 0;
    wait_done(100, c);
    vectors++;
    if (c !== DLY + 2) begin
      miscompares++; $display("FAIL areset_rerun_cycles: got %0d expected %0d", c, DLY + 2);
    end
    vectors++;
    if ({check_pass, id_mismatch, ts_mismatch, timeout_err} !== 4'b1000) begin
      miscompares++;
      $display("FAIL areset_rerun_flags: got %b expected %b", {check_pass, id_mismatch, ts_mismatch, timeout_err}, 4'b1000);
    end
  endtask

  task automatic test_random;
    int c, s0, s1, exp_c;
    bit to_id, to_ts, id_m, ts_m, pass;
    for (int it = 0; it < 24; it++) begin
      @(negedge clock);
      mem[0] = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
      mem[1] = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
      s0 = ($urandom_range(0, 3) == 3) ? int'($urandom_range(TMO - 1, TMO + 3)) : int'($urandom_range(0, 6));
      s1 = ($urandom_range(0, 3) == 3) ? int'($urandom_range(TMO - 1, TMO + 3)) : int'($urandom_range(0, 6));
      stall_cfg[0] = s0; stall_cfg[1] = s1;
      to_id = (s0 > TMO);
      to_ts = !to_id && (s1 > TMO);
      id_m  = !to_id && (mem[0] != EXP_ID);
      ts_m  = !to_id && !to_ts && (mem[1] != EXP_TS);
      pass  = !(id_m || ts_m || to_id || to_ts);
      exp_c = rd_cycles(s0) + (to_id ? 0 : rd_cycles(s1));
      recheck = 1'b1;
      @(negedge clock);
      recheck = 1'b0;
      @(negedge clock);
      vectors++;
      if (check_busy !== 1'b1) begin
        miscompares++; $display("FAIL rand%0d_start: got %b expected 1", it, check_busy);
      end
      wait_done(700, c);
      vectors++;
      if (c !== exp_c) begin
        miscompares++; $display("FAIL rand%0d_cycles: got %0d expected %0d (s0=%0d s1=%0d)", it, c, exp_c, s0, s1);
      end
      vectors++;
      if ({check_pass, id_mismatch, ts_mismatch, timeout_err} !== {pass, id_m, ts_m, to_id | to_ts}) begin
        miscompares++;
        $display("FAIL rand%0d_flags: got %b expected %b", it,
                 {check_pass, id_mismatch, ts_mismatch, timeout_err}, {pass, id_m, ts_m, to_id | to_ts});
      end
    end
    stall_cfg[0] = 0; stall_cfg[1] = 0;
  endtask

  initial begin
    reset = 1'b1; recheck = 1'b0; host_read = 1'b0; host_address = 1'b0;
    mem[0] = EXP_ID; mem[1] = EXP_TS;
    stall_cfg[0] = 0; stall_cfg[1] = 0;
    test_reset;
    test_nominal;
    test_id_mismatch;
    test_timeout;
    test_accept_wins;
    test_host_blocked;
    test_recheck_host_stall;
    test_recheck_on_done_entry;
    test_recheck_while_busy;
    test_async_reset;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
